// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and width helpers for the serial adder.
// result_width() is the same formula the pipelined adder tree uses, so the
// serial and parallel implementations agree on the result width.
package serial_adder_pkg;

    // Two-state frame controller: collecting words, or presenting a result.
    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

    // Width of a zero-extended sum of `inputs` unsigned words of `width` bits.
    function automatic int result_width(input int inputs, input int width);
        return width + $clog2(inputs);
    endfunction

    // Width needed to hold a word count from 0 up to and including `inputs`.
    function automatic int count_width(input int inputs);
        return $clog2(inputs + 1);
    endfunction

endpackage

// File: rtl/serial_adder_cnt.sv
// serial_adder_cnt: frame word counter for serial_adder.
// clr_i has priority over load_i, which has priority over inc_i.
// load_i starts a new frame at one word; tc_o flags that the next counted
// word completes a full frame of INPUTS_NUM words.
module serial_adder_cnt #(
    parameter int INPUTS_NUM = 125,
    parameter int CNT_WIDTH  = 7
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 clr_i,
    input  logic                 load_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 tc_o,
    output logic                 zero_o
);

    localparam logic [CNT_WIDTH-1:0] TC_VAL = CNT_WIDTH'(INPUTS_NUM - 1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Next count: clear at end of frame, load on a frame's first word, else count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CNT_WIDTH'(1);
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register; reset discards any partial frame.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign tc_o   = (cnt_q == TC_VAL);
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: sums a frame of INPUTS_NUM unsigned words arriving one per
// handshake and returns the zero-extended sum plus the word count.
// Optional feature macro: SERIAL_ADDER_TLAST_EN -- when defined, an accepted
// word with id_last = 1 ends the frame early.
//
// Handshake: a word is accepted on a cycle where id_valid & id_ready are both
// high at the rising edge; a result is taken where od_valid & od_ready are
// both high. id_ready depends only on state, od_ready and nrst (never on
// id_valid); od_valid is a registered state decode.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter  int INPUTS_NUM  = 125,
    parameter  int IDATA_WIDTH = 16,
    localparam int STAGES_NUM  = result_width(INPUTS_NUM, IDATA_WIDTH) - IDATA_WIDTH,
    localparam int ODATA_WIDTH = IDATA_WIDTH + STAGES_NUM,
    localparam int CNT_WIDTH   = count_width(INPUTS_NUM)
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   id_valid,
    output logic                   id_ready,
    input  logic [IDATA_WIDTH-1:0] idata,
    input  logic                   id_last,
    output logic                   od_valid,
    input  logic                   od_ready,
    output logic [ODATA_WIDTH-1:0] odata,
    output logic [CNT_WIDTH-1:0]   od_count,
    output logic                   dbg_state_o
);

    state_t                 state_q;
    state_t                 state_d;
    logic [ODATA_WIDTH-1:0] acc_q;
    logic [ODATA_WIDTH-1:0] acc_d;
    logic [ODATA_WIDTH-1:0] odata_q;
    logic [ODATA_WIDTH-1:0] odata_d;
    logic [CNT_WIDTH-1:0]   od_count_q;
    logic [CNT_WIDTH-1:0]   od_count_d;
    logic [ODATA_WIDTH-1:0] sum;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   tc;
    logic                   first;
    logic                   accept;
    logic                   take;
    logic                   last_en;
    logic                   frame_end;

`ifdef SERIAL_ADDER_TLAST_EN
    assign last_en = id_last;
`else
    // id_last has no effect in fixed-length frames.
    logic unused_id_last;
    assign unused_id_last = id_last;
    assign last_en        = 1'b0;
`endif

    assign od_valid  = (state_q == OUT);
    assign id_ready  = nrst & ((state_q == ACCUM) | od_ready);
    assign accept    = id_valid & id_ready;
    assign take      = od_valid & od_ready;
    assign frame_end = accept & (tc | last_en);

    // The first word of a frame replaces the accumulator instead of adding,
    // so no separate clear cycle is needed between frames.
    assign sum = first ? ODATA_WIDTH'(idata) : acc_q + ODATA_WIDTH'(idata);

    serial_adder_cnt #(
        .INPUTS_NUM (INPUTS_NUM),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_cnt (
        .clk    (clk),
        .nrst   (nrst),
        .clr_i  (frame_end),
        .load_i (accept & ~frame_end & first),
        .inc_i  (accept & ~frame_end & ~first),
        .cnt_o  (cnt),
        .tc_o   (tc),
        .zero_o (first)
    );

    // Next state: enter OUT on a frame end; leave OUT when the result is
    // taken unless the same cycle's word completes another frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: begin
                if (frame_end) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (take) begin
                    state_d = frame_end ? OUT : ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // Datapath next values: accumulate on accepts, capture result on frame end.
    always_comb begin
        acc_d      = acc_q;
        odata_d    = odata_q;
        od_count_d = od_count_q;
        if (accept) begin
            acc_d = sum;
        end
        if (frame_end) begin
            odata_d    = sum;
            od_count_d = cnt + 1'b1;
        end
    end

    // State and datapath registers; reset drops partial sums and pending results.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            odata_q    <= '0;
            od_count_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            odata_q    <= odata_d;
            od_count_q <= od_count_d;
        end
    end

    assign odata       = odata_q;
    assign od_count    = od_count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed test of serial_adder with INPUTS_NUM = 5,
// IDATA_WIDTH = 4 (ODATA_WIDTH = 7, CNT_WIDTH = 3).
module tb_serial_adder;

    localparam int INPUTS_NUM  = 5;
    localparam int IDATA_WIDTH = 4;
    localparam int ODATA_WIDTH = 7;
    localparam int CNT_WIDTH   = 3;

    logic                   clk;
    logic                   nrst;
    logic                   id_valid;
    logic                   id_ready;
    logic [IDATA_WIDTH-1:0] idata;
    logic                   id_last;
    logic                   od_valid;
    logic                   od_ready;
    logic [ODATA_WIDTH-1:0] odata;
    logic [CNT_WIDTH-1:0]   od_count;
    logic                   dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [ODATA_WIDTH-1:0] exp_q[$];
    logic [CNT_WIDTH-1:0]   exp_cnt_q[$];
    int                     take_cyc_q[$];
    int                     acc_cyc_q[$];

    serial_adder #(
        .INPUTS_NUM  (INPUTS_NUM),
        .IDATA_WIDTH (IDATA_WIDTH)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .idata       (idata),
        .id_last     (id_last),
        .od_valid    (od_valid),
        .od_ready    (od_ready),
        .odata       (odata),
        .od_count    (od_count),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk  = 1'b0;
        nrst = 1'b1;
    end
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic send_word(input logic [IDATA_WIDTH-1:0] d, input logic last);
        int waited;
        waited   = 0;
        id_valid = 1'b1;
        idata    = d;
        id_last  = last;
        #1;
        while (!id_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!id_ready) begin
            check("send_word_ready_timeout", id_ready, 1);
            id_valid = 1'b0;
            id_last  = 1'b0;
        end else begin
            acc_cyc_q.push_back(cyc);
            @(negedge clk);
            id_valid = 1'b0;
            id_last  = 1'b0;
        end
    endtask

    task automatic expect_result(input int sum, input int count);
        exp_q.push_back(ODATA_WIDTH'(sum));
        exp_cnt_q.push_back(CNT_WIDTH'(count));
    endtask

    // Wait until every expected result has been taken and od_valid drops.
    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || od_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending_results", exp_q.size(), 0);
    endtask

    // ---------------- scoreboard ----------------
    // Results are compared on the falling edge before the edge that takes them.
    always begin : result_monitor
        logic [ODATA_WIDTH-1:0] e;
        logic [CNT_WIDTH-1:0]   c;
        @(negedge clk);
        #1;
        if (nrst && od_valid && od_ready) begin
            take_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("spurious_result_od_valid", od_valid, 0);
            end else begin
                e = exp_q.pop_front();
                c = exp_cnt_q.pop_front();
                check("result_odata", odata, e);
                check("result_od_count", od_count, c);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        id_valid = 1'b0;
        idata    = '0;
        id_last  = 1'b0;
        od_ready = 1'b1;

        // Reset state
        #2 nrst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_id_ready", id_ready, 0);
        check("reset_od_valid", od_valid, 0);
        check("reset_odata", odata, 0);
        check("reset_od_count", od_count, 0);
        check("reset_state", dbg_state, 0);
        nrst = 1'b1;
        @(negedge clk);
        check("idle_id_ready", id_ready, 1);

        // 1..5 without stalls, result one cycle after the fifth accept
        expect_result(15, 5);
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) check("t1_no_early_valid", od_valid, 0);
            send_word(IDATA_WIDTH'(i), 1'b0);
        end
        check("t1_valid_after_last", od_valid, 1);
        drain();

        // Five maximum words: no truncation
        expect_result(75, 5);
        for (int i = 0; i < 5; i++) send_word(4'd15, 1'b0);
        drain();

        // Backpressure on the first result while the next frame waits
        od_ready = 1'b0;
        expect_result(5, 5);
        for (int i = 0; i < 5; i++) send_word(4'd1, 1'b0);
        id_valid = 1'b1;
        idata    = 4'd2;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t3_id_ready_held", id_ready, 0);
            check("t3_od_valid_held", od_valid, 1);
            check("t3_odata_held", odata, 5);
            @(negedge clk);
        end
        expect_result(10, 5);
        od_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_word(4'd2, 1'b0);
        drain();

        // Back-to-back frames, continuous valid and ready
        take_cyc_q.delete();
        acc_cyc_q.delete();
        expect_result(14, 5);
        expect_result(25, 5);
        send_word(4'd3, 1'b0);
        send_word(4'd1, 1'b0);
        send_word(4'd4, 1'b0);
        send_word(4'd1, 1'b0);
        send_word(4'd5, 1'b0);
        send_word(4'd9, 1'b0);
        send_word(4'd2, 1'b0);
        send_word(4'd6, 1'b0);
        send_word(4'd5, 1'b0);
        send_word(4'd3, 1'b0);
        drain();
        check("t4_take_count", take_cyc_q.size(), 2);
        check("t4_accept_count", acc_cyc_q.size(), 10);
        if (take_cyc_q.size() == 2 && acc_cyc_q.size() == 10) begin
            check("t4_frame2_first_word_with_take", acc_cyc_q[5], take_cyc_q[0]);
            check("t4_result_spacing", take_cyc_q[1] - take_cyc_q[0], 5);
            check("t4_no_bubble_span", acc_cyc_q[9] - acc_cyc_q[0], 9);
        end

        // Reset mid-frame
        for (int i = 0; i < 3; i++) send_word(4'd1, 1'b0);
        nrst = 1'b0;
        #1;
        check("t5_reset_id_ready", id_ready, 0);
        check("t5_reset_od_valid", od_valid, 0);
        check("t5_reset_odata", odata, 0);
        check("t5_reset_od_count", od_count, 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        expect_result(5, 5);
        for (int i = 0; i < 5; i++) send_word(4'd1, 1'b0);
        drain();

        // Early end of frame via id_last
`ifdef SERIAL_ADDER_TLAST_EN
        expect_result(15, 2);
        send_word(4'd7, 1'b0);
        send_word(4'd8, 1'b1);
        check("t6_tlast_valid", od_valid, 1);
        drain();
        expect_result(15, 5);
        for (int i = 1; i <= 5; i++) send_word(IDATA_WIDTH'(i), (i == 5));
        drain();
`else
        send_word(4'd7, 1'b0);
        send_word(4'd8, 1'b1);
        check("t6_last_ignored", od_valid, 0);
        expect_result(18, 5);
        for (int i = 0; i < 3; i++) send_word(4'd1, 1'b0);
        check("t6_full_frame_valid", od_valid, 1);
        drain();
`endif

        repeat (3) @(negedge clk);
        check("final_od_valid_idle", od_valid, 0);
        check("final_exp_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
